// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlymeas.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__dlymeas.sv - delay-chain measurement controller (launch edge, sync return, count cycles)
// Optional macro GF180MCU_DLYMEAS_SYNC_COMP_EN subtracts the synchronizer latency from normal results.
module gf180mcu_fd_sc_mcu7t5v0__dlymeas #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    output logic             LAUNCH,
    input  logic             RET,
    output logic             BUSY,
    output logic             DONE,
    output logic             TOUT,
    output logic [CNT_W-1:0] COUNT
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] SYNC_LAT = CNT_W'(SYNC_STAGES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_launch;
    logic                   r_done;
    logic                   r_tout;
    logic [CNT_W-1:0]       r_count;

    logic                   w_ret_s;
    logic                   w_match;
    logic                   w_cnt_last;
    logic                   w_launch_tgl;
    logic                   w_cnt_clr;
    logic                   w_cnt_inc;
    logic                   w_fin_ok;
    logic                   w_fin_to;
    logic                   w_tout_clr;
    logic                   w_busy;
    logic [CNT_W-1:0]       w_result;

    assign w_ret_s    = r_sync[SYNC_STAGES-1];
    assign w_match    = (w_ret_s == r_launch);
    // Timeout fires on the unmatched cycle that would bring cnt to all ones.
    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], RET};
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_nxt = w_match ? S_WAIT : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (w_match) begin
                    w_state_nxt = S_WAIT;
                end else if (w_cnt_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (w_match || w_cnt_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_launch_tgl = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_fin_ok     = 1'b0;
        w_fin_to     = 1'b0;
        w_tout_clr   = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_clr    = START;
                w_tout_clr   = START;
                w_launch_tgl = START && w_match;
            end
            S_SETTLE: begin
                w_busy       = 1'b1;
                w_launch_tgl = w_match;
                w_cnt_clr    = w_match;
                w_cnt_inc    = !w_match && (r_cnt != CNT_MAX);
                w_fin_to     = !w_match && w_cnt_last;
            end
            S_WAIT: begin
                w_busy    = 1'b1;
                w_fin_ok  = w_match;
                w_cnt_inc = !w_match && (r_cnt != CNT_MAX);
                w_fin_to  = !w_match && w_cnt_last;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

`ifdef GF180MCU_DLYMEAS_SYNC_COMP_EN
    assign w_result = (r_cnt >= SYNC_LAT) ? (r_cnt - SYNC_LAT) : '0;
`else
    assign w_result = r_cnt;
`endif

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_cnt    <= '0;
            r_launch <= 1'b0;
            r_done   <= 1'b0;
            r_tout   <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_launch_tgl) begin
                r_launch <= !r_launch;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_done <= w_fin_ok || w_fin_to;
            if (w_fin_to) begin
                r_count <= CNT_MAX;
                r_tout  <= 1'b1;
            end else if (w_fin_ok) begin
                r_count <= w_result;
            end else if (w_tout_clr) begin
                r_tout <= 1'b0;
            end
        end
    end

    assign LAUNCH = r_launch;
    assign BUSY   = w_busy;
    assign DONE   = r_done;
    assign TOUT   = r_tout;
    assign COUNT  = r_count;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__dlymeas.sv
// tb/tb_gf180mcu_fd_sc_mcu7t5v0__dlymeas.sv - directed bench for the delay measurement controller
module tb_gf180mcu_fd_sc_mcu7t5v0__dlymeas;

`ifdef GF180MCU_DLYMEAS_SYNC_COMP_EN
    localparam logic [3:0] EXP_ZERO = 4'd0;
    localparam logic [3:0] EXP_D5   = 4'd5;
`else
    localparam logic [3:0] EXP_ZERO = 4'd2;
    localparam logic [3:0] EXP_D5   = 4'd7;
`endif

    logic       CLK = 1'b0;
    logic       RN = 1'b0;
    logic       START = 1'b0;
    logic       LAUNCH;
    logic       RET;
    logic       BUSY;
    logic       DONE;
    logic       TOUT;
    logic [3:0] COUNT;

    int         mode = 0;
    logic       force_val = 1'b0;
    logic [4:0] dline;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 CLK = ~CLK;

    // Environment: loopback, 5-flop delayed loopback, or a forced level.
    always @(posedge CLK or negedge RN) begin
        if (!RN) dline <= '0;
        else     dline <= {dline[3:0], LAUNCH};
    end
    assign RET = (mode == 0) ? LAUNCH : (mode == 1) ? dline[4] : force_val;

    gf180mcu_fd_sc_mcu7t5v0__dlymeas #(.CNT_W(4), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RN(RN), .START(START), .LAUNCH(LAUNCH), .RET(RET),
        .BUSY(BUSY), .DONE(DONE), .TOUT(TOUT), .COUNT(COUNT)
    );

    task automatic do_reset();
        @(negedge CLK); RN = 1'b0; START = 1'b0;
        @(negedge CLK); RN = 1'b1;
    endtask

    // Pulse START for one cycle, report LAUNCH/BUSY after acceptance and cycles until DONE (-1 if none).
    task automatic run_meas(output logic l1, output logic b1, output int lat);
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        l1 = LAUNCH; b1 = BUSY; lat = 0;
        while (!DONE && lat < 40) begin
            @(negedge CLK); lat++;
        end
        if (!DONE) lat = -1;
    endtask

    task automatic test_reset();
        RN = 1'b0; #1;
        n_tests++;
        if ({LAUNCH, BUSY, DONE, TOUT, COUNT} !== 8'h00) begin
            n_fail++; $display("FAIL reset_outputs got %b expected 00000000", {LAUNCH, BUSY, DONE, TOUT, COUNT});
        end
        repeat (2) @(negedge CLK);
        RN = 1'b1;
    endtask

    task automatic test_zero_delay();
        logic l1, b1; int lat;
        do_reset(); mode = 0;
        run_meas(l1, b1, lat);
        n_tests++; if (l1 !== 1'b1 || b1 !== 1'b1) begin n_fail++; $display("FAIL zero_launch_busy got %b%b expected 11", l1, b1); end
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL zero_latency got %0d expected 3", lat); end
        n_tests++; if (COUNT !== EXP_ZERO || TOUT !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++; $display("FAIL zero_result got count=%0d tout=%b busy=%b expected count=%0d tout=0 busy=0", COUNT, TOUT, BUSY, EXP_ZERO);
        end
        @(negedge CLK);
        n_tests++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL zero_done_width got %b expected 0", DONE); end
    endtask

    task automatic test_delay5();
        logic l1, b1; int lat;
        do_reset(); mode = 1;
        run_meas(l1, b1, lat);
        n_tests++; if (l1 !== 1'b1 || lat != 8 || COUNT !== EXP_D5) begin
            n_fail++; $display("FAIL d5_rise got launch=%b lat=%0d count=%0d expected 1 8 %0d", l1, lat, COUNT, EXP_D5);
        end
        run_meas(l1, b1, lat);
        n_tests++; if (l1 !== 1'b0 || lat != 8 || COUNT !== EXP_D5 || TOUT !== 1'b0) begin
            n_fail++; $display("FAIL d5_fall got launch=%b lat=%0d count=%0d tout=%b expected 0 8 %0d 0", l1, lat, COUNT, TOUT, EXP_D5);
        end
    endtask

    task automatic test_timeout();
        logic l1, b1; int lat;
        do_reset(); mode = 2; force_val = 1'b0;
        run_meas(l1, b1, lat);
        n_tests++; if (lat != 15) begin n_fail++; $display("FAIL to_latency got %0d expected 15", lat); end
        n_tests++; if (COUNT !== 4'hF || TOUT !== 1'b1 || LAUNCH !== 1'b1) begin
            n_fail++; $display("FAIL to_result got count=%0d tout=%b launch=%b expected 15 1 1", COUNT, TOUT, LAUNCH);
        end
        @(negedge CLK);
        n_tests++; if (TOUT !== 1'b1) begin n_fail++; $display("FAIL to_hold got %b expected 1", TOUT); end
        START = 1'b1;
        @(negedge CLK); START = 1'b0;
        n_tests++; if (TOUT !== 1'b0 || BUSY !== 1'b1) begin
            n_fail++; $display("FAIL to_clear got tout=%b busy=%b expected 0 1", TOUT, BUSY);
        end
    endtask

    task automatic test_settle();
        int   lat;
        logic early;
        do_reset(); mode = 2; force_val = 1'b1;
        repeat (3) @(negedge CLK);
        START = 1'b1;
        @(negedge CLK); START = 1'b0;
        n_tests++; if (LAUNCH !== 1'b0 || BUSY !== 1'b1) begin
            n_fail++; $display("FAIL settle_enter got launch=%b busy=%b expected 0 1", LAUNCH, BUSY);
        end
        early = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (DONE) early = 1'b1;
        end
        mode = 0;
        lat = 0;
        while (!DONE && lat < 40) begin
            @(negedge CLK); lat++;
            if (DONE && LAUNCH === 1'b0) early = 1'b1;
        end
        n_tests++; if (early !== 1'b0) begin n_fail++; $display("FAIL settle_no_done got %b expected 0", early); end
        n_tests++; if (!DONE || LAUNCH !== 1'b1 || COUNT !== EXP_ZERO || TOUT !== 1'b0) begin
            n_fail++; $display("FAIL settle_result got done=%b launch=%b count=%0d tout=%b expected 1 1 %0d 0", DONE, LAUNCH, COUNT, TOUT, EXP_ZERO);
        end
    endtask

    task automatic test_back_to_back();
        int   cyc, toggles, dones;
        logic prev;
        do_reset(); mode = 1;
        @(negedge CLK); START = 1'b1;
        prev = LAUNCH; toggles = 0; dones = 0; cyc = 0;
        while (dones == 0 && cyc < 40) begin
            @(negedge CLK); cyc++;
            START = (cyc == 2 || cyc == 4 || cyc == 6);
            if (LAUNCH !== prev) toggles++;
            prev = LAUNCH;
            if (DONE) dones++;
        end
        n_tests++; if (toggles != 1 || dones != 1 || COUNT !== EXP_D5) begin
            n_fail++; $display("FAIL busy_ignore got toggles=%0d dones=%0d count=%0d expected 1 1 %0d", toggles, dones, COUNT, EXP_D5);
        end
        START = 1'b1;
        @(negedge CLK); START = 1'b0;
        n_tests++; if (BUSY !== 1'b1 || LAUNCH !== 1'b0) begin
            n_fail++; $display("FAIL b2b_accept got busy=%b launch=%b expected 1 0", BUSY, LAUNCH);
        end
        cyc = 0;
        while (!DONE && cyc < 40) begin @(negedge CLK); cyc++; end
        n_tests++; if (cyc != 8 || COUNT !== EXP_D5) begin
            n_fail++; $display("FAIL b2b_result got lat=%0d count=%0d expected 8 %0d", cyc, COUNT, EXP_D5);
        end
    endtask

    task automatic test_reset_mid();
        logic l1, b1; int lat;
        do_reset(); mode = 1;
        run_meas(l1, b1, lat);
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        repeat (3) @(negedge CLK);
        #2 RN = 1'b0;
        #1;
        n_tests++; if ({LAUNCH, BUSY, DONE, TOUT, COUNT} !== 8'h00) begin
            n_fail++; $display("FAIL rst_async got %b expected 00000000", {LAUNCH, BUSY, DONE, TOUT, COUNT});
        end
        repeat (2) @(negedge CLK);
        n_tests++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL rst_no_done got %b expected 0", DONE); end
        RN = 1'b1;
        run_meas(l1, b1, lat);
        n_tests++; if (l1 !== 1'b1 || lat != 8 || COUNT !== EXP_D5) begin
            n_fail++; $display("FAIL rst_fresh got launch=%b lat=%0d count=%0d expected 1 8 %0d", l1, lat, COUNT, EXP_D5);
        end
    endtask

    initial begin
        test_reset();
        test_zero_delay();
        test_delay5();
        test_timeout();
        test_settle();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
